regfile_hs: RTL



---
 rtl/regfile_hs_pkg.sv | 19 +
 rtl/regfile_rd_port.sv | 63 ++++++
 rtl/regfile_hs.sv | 119 +++++++++++
 3 files changed

// File: rtl/regfile_hs_pkg.sv
// Shared types and constants for the handshaked register file.
//   rd_state_e  : per-read-port FSM state (idle / holding data)
//   Def*        : default geometry used by the top and the read port
//   num_words() : number of registers for a given address width
package regfile_hs_pkg;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_HOLD = 1'b1
  } rd_state_e;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 5;

  function automatic int unsigned num_words(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port of regfile_hs: request/ack handshake in, held data out.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : read request, held by the requester until acked
//   stall_i      : addressed register has a pending write
//   ready_i      : consumer takes the held data this cycle
//   value_i      : already-bypassed value of the addressed register
//   ack_o        : request accepted this cycle (combinational)
//   valid_o      : data_o holds a read result (registered)
//   data_o       : held read data (registered)
module regfile_rd_port
  import regfile_hs_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 stall_i,
  input  logic                 ready_i,
  input  logic [DataWidth-1:0] value_i,
  output logic                 ack_o,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o
);

  rd_state_e            state_q, state_d;
  logic [DataWidth-1:0] data_q;
  logic                 can_take;

  // A new read may be taken when nothing is held, or when the held data is
  // consumed this very cycle (back-to-back, no bubble).
  assign can_take = (state_q == RD_IDLE) | ready_i;
  assign ack_o    = req_i & can_take & ~stall_i;

  // NOTE: combinational blocks assign every output a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (ack_o) begin
      state_d = RD_HOLD;
    end else if (ready_i) begin
      state_d = RD_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RD_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ack_o) begin
        data_q <= value_i;
      end
    end
  end

  assign valid_o = (state_q == RD_HOLD);
  assign data_o  = data_q;

endmodule

// File: rtl/regfile_hs.sv
// Register file with per-port request/acknowledge handshakes and a busy
// scoreboard that stalls reads of registers awaiting writeback.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   rd_req_i/rd_addr_i/rd_ack_o/rd_valid_o/rd_data_o/rd_ready_i
//                  : NumRead read ports, port p in slice p of each bus
//   wr_req_i/wr_addr_i/wr_data_i/wr_ack_o : write port, always accepted
//   lock_req_i/lock_addr_i/lock_ack_o     : reserve a destination register
//   busy_o         : registered scoreboard, one bit per register
module regfile_hs
  import regfile_hs_pkg::*;
#(
  parameter int unsigned          DataWidth  = DefDataWidth,
  parameter int unsigned          AddrWidth  = DefAddrWidth,
  parameter int unsigned          NumRead    = 2,
  parameter bit                   ZeroReg    = 1'b1,
  parameter logic [DataWidth-1:0] ResetValue = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumRead-1:0]             rd_req_i,
  input  logic [NumRead*AddrWidth-1:0]   rd_addr_i,
  output logic [NumRead-1:0]             rd_ack_o,
  output logic [NumRead-1:0]             rd_valid_o,
  output logic [NumRead*DataWidth-1:0]   rd_data_o,
  input  logic [NumRead-1:0]             rd_ready_i,
  input  logic                           wr_req_i,
  input  logic [AddrWidth-1:0]           wr_addr_i,
  input  logic [DataWidth-1:0]           wr_data_i,
  output logic                           wr_ack_o,
  input  logic                           lock_req_i,
  input  logic [AddrWidth-1:0]           lock_addr_i,
  output logic                           lock_ack_o,
  output logic [num_words(AddrWidth)-1:0] busy_o
);

  localparam int unsigned NumWords = num_words(AddrWidth);

  logic [DataWidth-1:0] mem [NumWords];
  logic [NumWords-1:0]  busy_q, busy_eff, busy_d;
  logic                 lock_is_zero;
  logic                 wr_en;

  assign wr_ack_o     = wr_req_i;
  assign wr_en        = wr_req_i & ~(ZeroReg && (wr_addr_i == '0));
  assign lock_is_zero = ZeroReg && (lock_addr_i == '0);

  // A write landing this cycle releases its register immediately, so locks
  // and reads of that register are not stalled by the stale busy bit.
  always_comb begin
    busy_eff = busy_q;
    if (wr_req_i) begin
      busy_eff[wr_addr_i] = 1'b0;
    end
  end

  assign lock_ack_o = lock_req_i & (~busy_eff[lock_addr_i] | lock_is_zero);

  // Lock is applied after the write release: write+lock to one address
  // leaves the register busy for the new producer.
  always_comb begin
    busy_d = busy_eff;
    if (lock_ack_o && !lock_is_zero) begin
      busy_d[lock_addr_i] = 1'b1;
    end
  end

  // NOTE: the storage is reset word by word, so it maps to flops rather
  // than a RAM macro; this is required because every register must come
  // out of reset with a known value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      for (int i = 0; i < NumWords; i++) begin
        mem[i] <= (ZeroReg && i == 0) ? '0 : ResetValue;
      end
    end else begin
      busy_q <= busy_d;
      if (wr_en) begin
        mem[wr_addr_i] <= wr_data_i;
      end
    end
  end

  assign busy_o = busy_q;

  for (genvar p = 0; p < NumRead; p++) begin : g_rd_port
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] value;
    logic                 stall;

    assign addr  = rd_addr_i[p*AddrWidth +: AddrWidth];
    assign stall = busy_eff[addr];

    // Hardwired zero wins over the same-cycle write bypass.
    always_comb begin
      value = mem[addr];
      if (ZeroReg && addr == '0) begin
        value = '0;
      end else if (wr_req_i && wr_addr_i == addr) begin
        value = wr_data_i;
      end
    end

    regfile_rd_port #(
      .DataWidth(DataWidth)
    ) u_rd_port (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req_i  (rd_req_i[p]),
      .stall_i(stall),
      .ready_i(rd_ready_i[p]),
      .value_i(value),
      .ack_o  (rd_ack_o[p]),
      .valid_o(rd_valid_o[p]),
      .data_o (rd_data_o[p*DataWidth +: DataWidth])
    );
  end

endmodule
